cdb_arbiter: RTL and testbench

Round-robin arbiter and output register for the common data bus. Reservation stations (three ALU stations plus the load/store buffer) each raise a result request carrying a ROB tag and data. One request per cycle is granted and broadcast on the registered CDB one cycle later, to the ROB, the reservation stations and issue_control. A flush input squashes arbitration and clears the bus on branch mispredict.

---
 rtl/cdb_if.sv | 17 +
 rtl/cdb_arbiter.sv | 56 +++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_if.sv
// cdb_if: request/grant and broadcast signals between the result producers and the CDB arbiter.
interface cdb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          flush;
    logic [NUM_REQ-1:0]            grant;
    logic                          cdb_valid;
    logic [TAG_WIDTH-1:0]          cdb_tag;
    logic [DATA_WIDTH-1:0]         cdb_data;
    modport master (output req, req_tag, req_data, flush, input grant, cdb_valid, cdb_tag, cdb_data);
    modport slave  (input req, req_tag, req_data, flush, output grant, cdb_valid, cdb_tag, cdb_data);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of result requests onto a registered common data bus,
// with a flush that squashes the grant and clears the bus.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    cdb_if.slave  bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0]         rr_ptr, win, nxt_ptr;
    logic                  found;
    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && bus.req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        // grant is gated by reset and flush only, never by tag or data
        found = found && rst_n && !bus.flush;
    end
    assign nxt_ptr   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign bus.grant = found ? (NUM_REQ'(1) << win) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else if (bus.flush) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= found;
            if (found) begin
                rr_ptr   <= nxt_ptr;
                cdb_tag  <= bus.req_tag[int'(win)*TAG_WIDTH +: TAG_WIDTH];
                cdb_data <= bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    assign bus.cdb_valid = cdb_valid;
    assign bus.cdb_tag   = cdb_tag;
    assign bus.cdb_data  = cdb_data;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scenario tasks check grants inline; a monitor pops expected broadcasts from a scoreboard.
module tb_cdb_arbiter;
    typedef struct {
        logic [2:0]  tag;
        logic [15:0] data;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  tg[4];
    logic [15:0] dt[4];
    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    cdb_if #(.NUM_REQ(4), .DATA_WIDTH(16), .TAG_WIDTH(3)) bus ();
    cdb_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .TAG_WIDTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.req_tag  = {tg[3], tg[2], tg[1], tg[0]};
    assign bus.req_data = {dt[3], dt[2], dt[1], dt[0]};
    always #5 clk = ~clk;
    // Broadcast for a grant seen in cycle n must be on the bus just after edge n+1.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            n_chk++;
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== e.tag || bus.cdb_data !== e.data) begin
                    n_fail++;
                    $display("FAIL cdb_broadcast: got v=%b tag=%0d data=%h expected v=1 tag=%0d data=%h",
                             bus.cdb_valid, bus.cdb_tag, bus.cdb_data, e.tag, e.data);
                end
            end else if (bus.cdb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cdb_idle: got cdb_valid=%b expected 0", bus.cdb_valid);
            end
        end
    end
    task automatic push_exp(input int k);
        exp_t e;
        e.tag  = tg[k];
        e.data = dt[k];
        q.push_back(e);
    endtask
    task automatic test_reset();
        bus.req = 4'b1111;
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tg[i] = 3'(i + 1);
            dt[i] = 16'hA000 + 16'(i);
        end
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_chk++;
        if (bus.grant !== 4'b0000 || bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 3'd0 || bus.cdb_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got g=%b v=%b tag=%0d data=%h expected all zero",
                     bus.grant, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 0001", bus.grant);
        end
        push_exp(0);
    endtask
    task automatic test_round_robin();
        logic [3:0] exp_g[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        int         exp_k[5] = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #3;
            n_chk++;
            if (bus.grant !== exp_g[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i, bus.grant, exp_g[i]);
            end
            push_exp(exp_k[i]);
        end
    endtask
    task automatic test_skip();
        logic [3:0] exp_g[2] = '{4'b0001, 4'b0010};
        int         exp_k[2] = '{0, 1};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            bus.req = 4'b0011;
            tg[i] = 3'(5 + i);
            #1;
            n_chk++;
            if (bus.grant !== exp_g[i]) begin
                n_fail++;
                $display("FAIL skip_grant[%0d]: got %b expected %b", i, bus.grant, exp_g[i]);
            end
            push_exp(exp_k[i]);
        end
    endtask
    task automatic test_flush();
        @(posedge clk);
        #2;
        bus.req = 4'b0110;
        bus.flush = 1'b1;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_grant: got %b expected 0000", bus.grant);
        end
        @(posedge clk);
        #2;
        bus.flush = 1'b0;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_ptr_reset: got %b expected 0010", bus.grant);
        end
        push_exp(1);
    endtask
    task automatic test_stream();
        tg[3] = 3'd6;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            bus.req = 4'b1000;
            dt[3] = 16'h1000 + 16'(i);
            #1;
            n_chk++;
            if (bus.grant !== 4'b1000) begin
                n_fail++;
                $display("FAIL stream_grant[%0d]: got %b expected 1000", i, bus.grant);
            end
            push_exp(3);
        end
    endtask
    task automatic test_idle();
        @(posedge clk);
        #2;
        bus.req = 4'b0100;
        tg[2] = 3'd5;
        dt[2] = 16'hBEEF;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL idle_setup_grant: got %b expected 0100", bus.grant);
        end
        push_exp(2);
        @(posedge clk);
        #2;
        bus.req = 4'b0000;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_grant: got %b expected 0000", bus.grant);
        end
        @(posedge clk);
        #2;
        n_chk++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 3'd5 || bus.cdb_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%b tag=%0d data=%h expected v=0 tag=5 data=beef",
                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        bus.req = 4'b1001;
        tg[3] = 3'd7;
        #1;
        n_chk++;
        if (bus.grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_ptr_held: got %b expected 1000", bus.grant);
        end
        push_exp(3);
    endtask
    task automatic test_async_reset();
        @(posedge clk);
        #2;
        bus.req = 4'b0001;
        tg[0] = 3'd2;
        dt[0] = 16'h5A5A;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL areset_setup_grant: got %b expected 0001", bus.grant);
        end
        push_exp(0);
        @(posedge clk);
        #2;
        bus.req = 4'b1100;
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        n_chk++;
        if (bus.grant !== 4'b0000 || bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 3'd0 || bus.cdb_data !== 16'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: got g=%b v=%b tag=%0d data=%h expected all zero",
                     bus.grant, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (bus.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL areset_restart: got %b expected 0100", bus.grant);
        end
        push_exp(2);
        @(posedge clk);
        #2;
        bus.req = 4'b0000;
        repeat (2) @(posedge clk);
        #2;
    endtask
    initial begin
        bus.req = 4'b0000;
        bus.flush = 1'b0;
        test_reset();
        test_round_robin();
        test_skip();
        test_flush();
        test_stream();
        test_idle();
        test_async_reset();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
